// File: rtl/led_matrix_scan.sv
// led_matrix_scan: double-buffered, row-multiplexed LED matrix driver.
// An image arrives over a valid/ready handshake into a pending buffer. It is
// promoted to the active buffer only at a frame boundary, so a frame never
// tears. Every row gets a blanking gap with all rows off, then a dwell period
// with its row driver on and its pixels on the column drivers.
module led_matrix_scan #(
    parameter int ROWS           = 6,
    parameter int COLS           = 6,
    parameter int DWELL_CYCLES   = 2000,
    parameter int BLANK_CYCLES   = 8,
    parameter int ROW_ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS*COLS-1:0] img_in,
    input  logic                 img_valid,
    output logic                 img_ready,
    output logic [ROWS-1:0]      row_sel,
    output logic [COLS-1:0]      col_data,
    output logic                 frame_start
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [ROWS-1:0]  ROWS_OFF   = (ROW_ACTIVE_LOW != 0) ? {ROWS{1'b1}} : {ROWS{1'b0}};

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    state_t               state;
    logic [ROW_W-1:0]     row;
    logic [CNT_W-1:0]     cnt;
    logic [ROWS*COLS-1:0] pending;
    logic [ROWS*COLS-1:0] active;
    logic                 pending_full;

    // Row driver pattern selecting row r, honouring the driver polarity.
    function automatic logic [ROWS-1:0] row_drive(input logic [ROW_W-1:0] r);
        logic [ROWS-1:0] onehot;
        onehot = ROWS'(1) << r;
        return (ROW_ACTIVE_LOW != 0) ? ~onehot : onehot;
    endfunction

    // Ready is simply "pending buffer is empty"; it comes straight off a flop.
    assign img_ready = ~pending_full;

    // Handshake capture, buffer swap and the IDLE/BLANK/DRIVE scan sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            row          <= '0;
            cnt          <= '0;
            pending      <= '0;
            active       <= '0;
            pending_full <= 1'b0;
            row_sel      <= ROWS_OFF;
            col_data     <= '0;
            frame_start  <= 1'b0;
        end else begin
            frame_start <= 1'b0;

            // A swap needs pending_full=1 and an accept needs it 0, so the two
            // updates of pending_full below can never collide.
            if (img_valid && !pending_full) begin
                pending      <= img_in;
                pending_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pending_full) begin
                        state        <= BLANK;
                        row          <= '0;
                        cnt          <= '0;
                        active       <= pending;
                        pending_full <= 1'b0;
                        frame_start  <= 1'b1;
                    end
                end

                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state    <= DRIVE;
                        cnt      <= '0;
                        row_sel  <= row_drive(row);
                        col_data <= active[int'(row)*COLS +: COLS];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DRIVE: begin
                    if (cnt == DWELL_LAST) begin
                        state    <= BLANK;
                        cnt      <= '0;
                        row_sel  <= ROWS_OFF;
                        col_data <= '0;
                        if (row == ROW_LAST) begin
                            // Frame boundary: the only place a new image may take over.
                            row         <= '0;
                            frame_start <= 1'b1;
                            if (pending_full) begin
                                active       <= pending;
                                pending_full <= 1'b0;
                            end
                        end else begin
                            row <= row + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    row_sel  <= ROWS_OFF;
                    col_data <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Testbench for led_matrix_scan with ROWS=6 COLS=6 DWELL=4 BLANK=2, active-low rows.
// A frame-phase reference model predicts the outputs for each clock; the
// prediction is queued at the edge and popped when the DUT output is sampled.
module tb_led_matrix_scan;

    localparam int ROWS  = 6;
    localparam int COLS  = 6;
    localparam int DWELL = 4;
    localparam int BLANK = 2;
    localparam int RPER  = BLANK + DWELL;
    localparam int FPER  = ROWS * RPER;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [ROWS*COLS-1:0] img_in = '0;
    logic                 img_valid = 1'b0;
    logic                 img_ready;
    logic [ROWS-1:0]      row_sel;
    logic [COLS-1:0]      col_data;
    logic                 frame_start;

    int checks = 0;
    int failures = 0;
    string cur_test = "";

    // reference model state
    bit                   m_running;
    int                   m_t;
    logic [ROWS*COLS-1:0] m_cur;
    logic [ROWS*COLS-1:0] m_pend;
    bit                   m_pf;
    bit                   m_acc;
    int                   m_cycle;

    // expected {row_sel, col_data, frame_start, img_ready}
    logic [13:0] exp_q[$];

    led_matrix_scan #(
        .ROWS(ROWS),
        .COLS(COLS),
        .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLANK),
        .ROW_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .img_in(img_in),
        .img_valid(img_valid),
        .img_ready(img_ready),
        .row_sel(row_sel),
        .col_data(col_data),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic logic [13:0] model_out();
        int r;
        int p;
        logic [5:0] rs;
        logic [5:0] c;
        logic fs;
        if (!m_running) return {6'h3F, 6'h00, 1'b0, ~m_pf};
        r  = m_t / RPER;
        p  = m_t % RPER;
        fs = (m_t == 0);
        if (p < BLANK) begin
            rs = 6'h3F;
            c  = 6'h00;
        end else begin
            rs = ~(6'b000001 << r);
            c  = m_cur[r*COLS +: COLS];
        end
        return {rs, c, fs, ~m_pf};
    endfunction

    task automatic model_reset();
        m_running = 0;
        m_t = 0;
        m_cur = '0;
        m_pend = '0;
        m_pf = 0;
        exp_q.delete();
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare at negedge.
    task automatic step(input logic v, input logic [ROWS*COLS-1:0] d);
        bit old_pf;
        logic [13:0] got;
        logic [13:0] e;
        img_valid = v;
        img_in    = d;
        @(posedge clk);
        old_pf = m_pf;
        m_acc  = v && !old_pf;
        if (m_running) begin
            m_t = (m_t + 1) % FPER;
            if (m_t == 0 && old_pf) begin
                m_cur = m_pend;
                m_pf  = 0;
            end
        end else if (old_pf) begin
            m_running = 1;
            m_t   = 0;
            m_cur = m_pend;
            m_pf  = 0;
        end
        if (m_acc) begin
            m_pend = d;
            m_pf   = 1;
        end
        exp_q.push_back(model_out());
        @(negedge clk);
        m_cycle++;
        got = {row_sel, col_data, frame_start, img_ready};
        e   = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s cycle=%0d phase=%0d: got row_sel=%h col=%h fs=%b rdy=%b, expected row_sel=%h col=%h fs=%b rdy=%b",
                     cur_test, m_cycle, m_t, got[13:8], got[7:2], got[1], got[0], e[13:8], e[7:2], e[1], e[0]);
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    // Hold img_valid with d until the model sees it accepted (bounded).
    task automatic offer(input logic [ROWS*COLS-1:0] d, input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            step(1'b1, d);
            done = m_acc;
        end
        img_valid = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s accept: got not accepted within %0d cycles, expected acceptance", cur_test, budget);
        end
    endtask

    task automatic wait_phase(input int ph, input int budget);
        for (int i = 0; i < budget && m_t != ph; i++) step(1'b0, '0);
        checks++;
        if (m_t != ph) begin
            failures++;
            $display("FAIL %s phase_wait: got phase %0d, expected %0d", cur_test, m_t, ph);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        img_valid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cur_test = "reset_idle";
        do_reset();
        idle_steps(100);
    endtask

    task automatic test_single_row();
        cur_test = "single_row";
        offer(36'h00000003F, 4);
        idle_steps(FPER + 8);
    endtask

    task automatic test_diagonal();
        cur_test = "diagonal";
        do_reset();
        idle_steps(3);
        offer(36'h810204081, 4);
        idle_steps(2 * FPER + 4);
    endtask

    task automatic test_swap_mid_frame();
        cur_test = "swap_mid_frame";
        wait_phase(2 * RPER + BLANK, 2 * FPER);
        offer(36'hA5C3_96F0_E, 2);
        idle_steps(2 * FPER);
    endtask

    task automatic test_hold_valid();
        cur_test = "hold_valid";
        offer({4'h0, $urandom()}, 4);
        offer(36'h5_5555_AAAA, 3 * FPER);
        idle_steps(2 * FPER + 3);
    endtask

    task automatic test_reset_mid_drive();
        cur_test = "reset_mid_drive";
        wait_phase(3 * RPER + BLANK + 1, 2 * FPER);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (row_sel !== 6'h3F) begin
            failures++;
            $display("FAIL async_rst_row_sel: got %h, expected 3f", row_sel);
        end
        checks++;
        if (col_data !== 6'h00) begin
            failures++;
            $display("FAIL async_rst_col_data: got %h, expected 00", col_data);
        end
        checks++;
        if (img_ready !== 1'b1 || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL async_rst_ctrl: got rdy=%b fs=%b, expected rdy=1 fs=0", img_ready, frame_start);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cur_test = "after_reset_idle";
        idle_steps(40);
    endtask

    task automatic test_zero_image();
        cur_test = "zero_image";
        offer(36'h0, 4);
        idle_steps(FPER + 4);
    endtask

    task automatic test_back_to_back();
        cur_test = "back_to_back";
        offer(36'hF_0F0F_0F0F, 4);
        offer(36'h0_F0F0_F0F0, 3 * FPER);
        offer(36'h3_FFFF_FFFF, 3 * FPER);
        idle_steps(2 * FPER);
    endtask

    initial begin
        model_reset();
        m_cycle = 0;
        test_reset();
        test_single_row();
        test_diagonal();
        test_swap_mid_frame();
        test_hold_valid();
        test_reset_mid_drive();
        test_zero_image();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
